// File: rtl/riscv_mem_stage.sv
// Memory-access stage: drives loads/stores onto the req/gnt/rvalid data bus,
// builds byte enables and lane-replicated store data, extends load data.
module riscv_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  rd_idx_i,
  input  logic        rd_we_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [4:0]  rd_idx_o,
  output logic        rd_we_o,
  output logic [31:0] rd_wdata_o,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic        data_re_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state;
  logic        mem_op, is_byte, is_half, misalign, aligned_op;
  logic        granted, complete, out_valid;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign mem_op     = valid_i & (mem_re_i | mem_we_i);
  assign is_byte    = (funct3_i[1:0] == 2'b00);
  assign is_half    = (funct3_i[1:0] == 2'b01);
  assign misalign   = mem_op & ((is_half & alu_result_i[0]) |
                                (!is_byte && !is_half && alu_result_i[1:0] != 2'b00));
  assign aligned_op = mem_op & ~misalign;

  // Handshake: a request is accepted in the cycle dmem_req_o & dmem_gnt_i; while
  // waiting for gnt every request field stays stable. Read data arrives only
  // with dmem_rvalid_i in a later cycle, and is only honoured in S_RESP.
  assign dmem_req_o = !rst && ((state == S_IDLE && aligned_op) || state == S_REQ);
  assign granted    = dmem_req_o & dmem_gnt_i;
  assign complete   = !rst && ((granted && mem_we_i) || (state == S_RESP && dmem_rvalid_i));
  assign stall_o    = !rst && ((state == S_IDLE && aligned_op) || state != S_IDLE) && !complete;
  assign misalign_o = !rst && state == S_IDLE && misalign;

  assign out_valid  = (valid_i && !mem_re_i && !mem_we_i) || complete;
  assign rd_we_o    = !rst && out_valid && rd_we_i;
  assign data_we_o  = complete && mem_we_i;
  assign data_re_o  = complete && mem_re_i;
  assign rd_idx_o   = rd_idx_i;
  assign data_addr_o = alu_result_i;
  assign rd_wdata_o = mem_re_i ? load_ext : alu_result_i;

  assign dmem_we_o   = mem_we_i;
  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};
  assign state_o     = state;

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = store_data_i;
    if (mem_we_i) begin
      if (is_byte) begin
        dmem_be_o    = 4'b0001 << alu_result_i[1:0];
        dmem_wdata_o = {4{store_data_i[7:0]}};
      end else if (is_half) begin
        dmem_be_o    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        dmem_wdata_o = {2{store_data_i[15:0]}};
      end
    end
  end

  always_comb begin
    case (alu_result_i[1:0])
      2'd0:    byte_sel = dmem_rdata_i[7:0];
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    half_sel = alu_result_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_i)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:
          if (aligned_op)
            state <= dmem_gnt_i ? (mem_we_i ? S_IDLE : S_RESP) : S_REQ;
        S_REQ:
          if (dmem_gnt_i)
            state <= mem_we_i ? S_IDLE : S_RESP;
        S_RESP:
          if (dmem_rvalid_i)
            state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
